// File: rtl/pairwise_collision_scanner.sv
// Sequential all-pairs sprite collision scanner: one unordered pair per cycle through a shared
// 3-stage squared-distance pipeline. Define COLLISION_SCAN_ABORT_EN to add the abort/aborted ports.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; inputs snapshotted on acceptance
// S_SCAN  | issuing one (i,j) pair per cycle in row-major order
// S_DRAIN | 3 cycles letting the last pairs leave the pipeline
// S_DONE  | one-cycle done pulse; results final
module pairwise_collision_scanner #(
   parameter int SPRITES    = 9,
   parameter int DIMENSIONS = 2,
   parameter int WIDTH      = 32,
   parameter int FRAC       = 0,
   parameter int RADIUS_W   = 7,
   localparam int PAIRS     = SPRITES*(SPRITES-1)/2,
   localparam int CNT_W     = $clog2(PAIRS+1)
) (
   input  logic                                          clock,
   input  logic                                          reset_L,
   input  logic                                          start,
`ifdef COLLISION_SCAN_ABORT_EN
   input  logic                                          abort,
   output logic                                          aborted,
`endif
   input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] locations,
   input  logic [SPRITES-1:0][RADIUS_W-1:0]              radii,
   input  logic [SPRITES-1:0][WIDTH-1:0]                 masses,
   output logic                                          busy,
   output logic                                          done,
   output logic [SPRITES-1:0][SPRITES-1:0]               collision,
   output logic [CNT_W-1:0]                              collision_count
);

   localparam int IDX_W = (SPRITES > 2) ? $clog2(SPRITES) : 1;
   localparam int DIF_W = WIDTH + 1;
   localparam int SQ_W  = 2*WIDTH + 2;
   localparam int RS_W  = RADIUS_W + 1;
   localparam int RSQ_W = 2*RADIUS_W + 2;
   localparam int D2_W  = SQ_W + 2;
   localparam int TH_W  = RSQ_W + 2*FRAC;
   localparam int CMP_W = (D2_W > TH_W) ? D2_W : TH_W;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

   state_t                                        state_q, state_d;
   logic [IDX_W-1:0]                              i_q, i_d, j_q, j_d;
   logic [1:0]                                    drain_q, drain_d;
   logic                                          abort_hit;

   logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] loc_q;
   logic [SPRITES-1:0][RADIUS_W-1:0]              rad_q;
   logic [SPRITES-1:0]                            act_q;

   logic                                          s1_v_q, s1_act_q;
   logic [IDX_W-1:0]                              s1_i_q, s1_j_q;
   logic [DIMENSIONS-1:0][DIF_W-1:0]              s1_dif_q;
   logic [RS_W-1:0]                               s1_rs_q;

   logic                                          s2_v_q, s2_act_q;
   logic [IDX_W-1:0]                              s2_i_q, s2_j_q;
   logic [DIMENSIONS-1:0][SQ_W-1:0]               s2_sq_q;
   logic [RSQ_W-1:0]                              s2_rsq_q;

   logic                                          s3_v_q, s3_hit_q;
   logic [IDX_W-1:0]                              s3_i_q, s3_j_q;

   logic [SPRITES-1:0][SPRITES-1:0]               col_q, diag;
   logic [CNT_W-1:0]                              cnt_q;

   logic [DIMENSIONS-1:0][DIF_W-1:0]              dif_d;
   logic [DIMENSIONS-1:0][SQ_W-1:0]               sq_d;
   logic signed [SQ_W-1:0]                        dif_ext;
   logic [RS_W-1:0]                               rs_d;
   logic [RSQ_W-1:0]                              rsq_d;
   logic [CMP_W-1:0]                              d2, thresh;
   logic                                          hit_d;

   always_comb begin
      diag = '0;
      for (int k = 0; k < SPRITES; k++) diag[k][k] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      drain_d   = drain_q;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      abort_hit = 1'b0;
`ifdef COLLISION_SCAN_ABORT_EN
      abort_hit = abort && ((state_q == S_SCAN) || (state_q == S_DRAIN));
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SCAN;
               i_d     = '0;
               j_d     = IDX_W'(1);
            end
         end
         S_SCAN: begin
            if (i_q == IDX_W'(SPRITES-2) && j_q == IDX_W'(SPRITES-1)) begin
               state_d = S_DRAIN;
               drain_d = 2'd2;
            end else if (j_q == IDX_W'(SPRITES-1)) begin
               i_d = i_q + IDX_W'(1);
               j_d = i_q + IDX_W'(2);
            end else begin
               j_d = j_q + IDX_W'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == 2'd0) state_d = S_DONE;
            else                 drain_d = drain_q - 2'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort_hit) state_d = S_IDLE;
   end

   // Differences are formed one bit wider so max-positive minus max-negative cannot wrap.
   always_comb begin
      dif_d   = '0;
      sq_d    = '0;
      dif_ext = '0;
      d2      = '0;
      for (int d = 0; d < DIMENSIONS; d++) begin
         dif_d[d] = {loc_q[i_q][d][WIDTH-1], loc_q[i_q][d]} - {loc_q[j_q][d][WIDTH-1], loc_q[j_q][d]};
         dif_ext  = SQ_W'($signed(s1_dif_q[d]));
         sq_d[d]  = dif_ext * dif_ext;
         d2       = d2 + CMP_W'(s2_sq_q[d]);
      end
      rs_d   = {1'b0, rad_q[i_q]} + {1'b0, rad_q[j_q]};
      rsq_d  = RSQ_W'(s1_rs_q) * RSQ_W'(s1_rs_q);
      thresh = CMP_W'(s2_rsq_q) << (2*FRAC);
      hit_d  = (d2 <= thresh) && s2_act_q;
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= S_IDLE;
         i_q      <= '0;
         j_q      <= '0;
         drain_q  <= '0;
         loc_q    <= '0;
         rad_q    <= '0;
         act_q    <= '0;
         s1_v_q   <= 1'b0;
         s1_act_q <= 1'b0;
         s1_i_q   <= '0;
         s1_j_q   <= '0;
         s1_dif_q <= '0;
         s1_rs_q  <= '0;
         s2_v_q   <= 1'b0;
         s2_act_q <= 1'b0;
         s2_i_q   <= '0;
         s2_j_q   <= '0;
         s2_sq_q  <= '0;
         s2_rsq_q <= '0;
         s3_v_q   <= 1'b0;
         s3_hit_q <= 1'b0;
         s3_i_q   <= '0;
         s3_j_q   <= '0;
         col_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         drain_q  <= drain_d;

         s1_v_q   <= (state_q == S_SCAN) && !abort_hit;
         s1_act_q <= act_q[i_q] && act_q[j_q];
         s1_i_q   <= i_q;
         s1_j_q   <= j_q;
         s1_dif_q <= dif_d;
         s1_rs_q  <= rs_d;

         s2_v_q   <= s1_v_q && !abort_hit;
         s2_act_q <= s1_act_q;
         s2_i_q   <= s1_i_q;
         s2_j_q   <= s1_j_q;
         s2_sq_q  <= sq_d;
         s2_rsq_q <= rsq_d;

         s3_v_q   <= s2_v_q && !abort_hit;
         s3_hit_q <= hit_d;
         s3_i_q   <= s2_i_q;
         s3_j_q   <= s2_j_q;

         if (state_q == S_IDLE && start) begin
            loc_q <= locations;
            rad_q <= radii;
            for (int s = 0; s < SPRITES; s++) act_q[s] <= |masses[s];
            col_q <= diag;
            cnt_q <= '0;
         end else if (s3_v_q && s3_hit_q && !abort_hit) begin
            col_q[s3_i_q][s3_j_q] <= 1'b1;
            col_q[s3_j_q][s3_i_q] <= 1'b1;
            cnt_q                 <= cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef COLLISION_SCAN_ABORT_EN
   logic aborted_q;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) aborted_q <= 1'b0;
      else          aborted_q <= abort_hit;
   end

   assign aborted = aborted_q;
`endif

   assign collision       = col_q;
   assign collision_count = cnt_q;

endmodule

// File: tb/tb_pairwise_collision_scanner.sv
// Scoreboard bench for pairwise_collision_scanner: a 2D/32-bit instance and a 3D/16-bit/FRAC=2
// instance, checked against an arithmetic all-pairs reference model.
module tb_pairwise_collision_scanner;
   localparam int S     = 9;
   localparam int PAIRS = S*(S-1)/2;
   localparam int LAT   = PAIRS + 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_L, start_a, start_b;
   logic [S-1:0][1:0][31:0] loc_a;
   logic [S-1:0][2:0][15:0] loc_b;
   logic [S-1:0][6:0]       rad;
   logic [S-1:0][31:0]      mass_a;
   logic [S-1:0][15:0]      mass_b;
   logic busy_a, done_a, busy_b, done_b;
   logic [S-1:0][S-1:0] col_a, col_b;
   logic [5:0] cnt_a, cnt_b;
`ifdef COLLISION_SCAN_ABORT_EN
   logic abort_a, aborted_a, abort_b, aborted_b;
`endif

   longint st_loc [S][3];
   int     st_rad [S];
   longint st_mass[S];

   always_comb begin
      for (int s = 0; s < S; s++) begin
         rad[s]    = st_rad[s][6:0];
         mass_a[s] = st_mass[s][31:0];
         mass_b[s] = st_mass[s][15:0];
         for (int d = 0; d < 2; d++) loc_a[s][d] = st_loc[s][d][31:0];
         for (int d = 0; d < 3; d++) loc_b[s][d] = st_loc[s][d][15:0];
      end
   end

   pairwise_collision_scanner #(.SPRITES(S), .DIMENSIONS(2), .WIDTH(32), .FRAC(0), .RADIUS_W(7)) dut_a (
      .clock(clock), .reset_L(reset_L), .start(start_a),
`ifdef COLLISION_SCAN_ABORT_EN
      .abort(abort_a), .aborted(aborted_a),
`endif
      .locations(loc_a), .radii(rad), .masses(mass_a),
      .busy(busy_a), .done(done_a), .collision(col_a), .collision_count(cnt_a));

   pairwise_collision_scanner #(.SPRITES(S), .DIMENSIONS(3), .WIDTH(16), .FRAC(2), .RADIUS_W(7)) dut_b (
      .clock(clock), .reset_L(reset_L), .start(start_b),
`ifdef COLLISION_SCAN_ABORT_EN
      .abort(abort_b), .aborted(aborted_b),
`endif
      .locations(loc_b), .radii(rad), .masses(mass_b),
      .busy(busy_b), .done(done_b), .collision(col_b), .collision_count(cnt_b));

   typedef struct {
      logic [S-1:0][S-1:0] mat;
      int                  cnt;
      longint              acc;
   } exp_t;

   exp_t   q_a[$], q_b[$];
   int     checks = 0, failures = 0;
   longint cyc = 0;
   int     dn[2];
   int     busy_n[2];
   bit     stab[2];
   logic [S-1:0][S-1:0] last[2];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: squared Euclidean distance vs squared radius sum scaled to the location grid.
   function automatic void model(input int id, output logic [S-1:0][S-1:0] mat, output int cnt);
      int          dims, frac, rs;
      longint      df;
      logic [127:0] d2, thr;
      dims = (id == 0) ? 2 : 3;
      frac = (id == 0) ? 0 : 2;
      mat = '0;
      cnt = 0;
      for (int i = 0; i < S; i++) mat[i][i] = 1'b1;
      for (int i = 0; i < S; i++)
         for (int j = i + 1; j < S; j++) begin
            d2 = '0;
            for (int d = 0; d < dims; d++) begin
               df = st_loc[i][d] - st_loc[j][d];
               if (df < 0) df = -df;
               d2 = d2 + 128'(df) * 128'(df);
            end
            rs  = st_rad[i] + st_rad[j];
            thr = 128'(rs * rs) << (2*frac);
            if (d2 <= thr && st_mass[i] != 0 && st_mass[j] != 0) begin
               mat[i][j] = 1'b1;
               mat[j][i] = 1'b1;
               cnt++;
            end
         end
   endfunction

   task automatic mon(input int id, input logic busy, input logic done,
                      input logic [S-1:0][S-1:0] mat, input logic [7:0] cnt);
      exp_t  e;
      string p;
      p = (id == 0) ? "a" : "b";
      if (!reset_L) begin
         last[id]   = '0;
         busy_n[id] = 0;
      end else begin
         if (busy) busy_n[id]++;
         if (done) begin
            dn[id]++;
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
               checks++;
               failures++;
               $display("FAIL %s_unexpected_done actual=done required=no_done", p);
            end else begin
               if (id == 0) e = q_a.pop_front();
               else         e = q_b.pop_front();
               chk({p, "_matrix"}, mat, e.mat);
               chk({p, "_count"}, cnt, e.cnt);
               chk({p, "_done_latency"}, cyc - e.acc + 1, LAT);
               chk({p, "_busy_cycles"}, busy_n[id], LAT);
               last[id] = e.mat;
               stab[id] = 1'b1;
            end
            busy_n[id] = 0;
         end else if (!busy && stab[id]) begin
            chk({p, "_hold"}, mat, last[id]);
         end
      end
   endtask

   always @(negedge clock) begin
      mon(0, busy_a, done_a, col_a, {2'b00, cnt_a});
      mon(1, busy_b, done_b, col_b, {2'b00, cnt_b});
   end

   task automatic launch(input int id, input bit hold);
      exp_t e;
      model(id, e.mat, e.cnt);
      @(negedge clock);
      if (id == 0) start_a = 1'b1;
      else         start_b = 1'b1;
      @(posedge clock);
      #1;
      e.acc = cyc;
      if (id == 0) q_a.push_back(e);
      else         q_b.push_back(e);
      if (!hold) begin
         start_a = 1'b0;
         start_b = 1'b0;
      end
   endtask

   task automatic wait_n(input int id, input int target, input int limit);
      for (int k = 0; k < limit && dn[id] < target; k++) begin
         @(negedge clock);
         #1;
      end
      checks++;
      if (dn[id] < target) begin
         failures++;
         $display("FAIL wait_done_%0d actual=%0d required=%0d", id, dn[id], target);
      end
   endtask

   task automatic sweep(input int id);
      int base;
      base = dn[id];
      launch(id, 1'b0);
      wait_n(id, base + 1, 80);
   endtask

   task automatic setup_far();
      for (int s = 0; s < S; s++) begin
         for (int d = 0; d < 3; d++) st_loc[s][d] = 3000 * s;
         st_rad[s]  = 1;
         st_mass[s] = 1;
      end
   endtask

   task automatic rand_stim(input int id);
      for (int s = 0; s < S; s++) begin
         for (int d = 0; d < 3; d++) begin
            if (id == 0)
               st_loc[s][d] = ($urandom_range(0, 9) == 0) ? longint'($signed($urandom()))
                                                           : longint'(int'($urandom_range(0, 40)) - 20);
            else
               st_loc[s][d] = ($urandom_range(0, 9) == 0) ? longint'($signed(16'($urandom())))
                                                           : longint'(int'($urandom_range(0, 80)) - 40);
         end
         st_rad[s]  = (id == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 10));
         st_mass[s] = ($urandom_range(0, 4) == 0) ? 0 : longint'($urandom_range(1, 1000));
      end
   endtask

   initial begin
      logic [S-1:0][S-1:0] diag;
      exp_t e;
      int   base;
      diag = '0;
      for (int k = 0; k < S; k++) diag[k][k] = 1'b1;
      stab[0] = 1'b1;
      stab[1] = 1'b1;
      reset_L = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
`ifdef COLLISION_SCAN_ABORT_EN
      abort_a = 1'b0;
      abort_b = 1'b0;
`endif
      setup_far();
      #12;
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_col_a", col_a, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_col_b", col_b, 0);
      chk("rst_cnt_b", cnt_b, 0);
      @(posedge clock);
      #1 reset_L = 1'b1;

      // touching pair (d2 = 25 = (2+3)^2)
      st_loc[0][0] = 0; st_loc[0][1] = 0;
      st_loc[1][0] = 3; st_loc[1][1] = 4;
      st_rad[0] = 2; st_rad[1] = 3;
      sweep(0);
      chk("t1_m01", col_a[0][1], 1);
      chk("t1_m10", col_a[1][0], 1);
      chk("t1_cnt", cnt_a, 1);

      st_loc[1][1] = 5;
      sweep(0);
      chk("t2_mat", col_a, diag);
      chk("t2_cnt", cnt_a, 0);

      st_loc[1][0] = 0; st_loc[1][1] = 0;
      st_mass[1] = 0;
      sweep(0);
      chk("t3_cnt_inactive", cnt_a, 0);
      st_mass[1] = 1;
      sweep(0);
      chk("t3_cnt_coincident", cnt_a, 1);

      // back-to-back sweeps with start held high
      rand_stim(0);
      base = dn[0];
      launch(0, 1'b1);
      model(0, e.mat, e.cnt);
      e.acc = cyc + PAIRS + 5;
      q_a.push_back(e);
      repeat (PAIRS + 5) @(posedge clock);
      #1 start_a = 1'b0;
      wait_n(0, base + 2, 120);

      // inputs and start change mid-sweep; the snapshot must win
      rand_stim(0);
      base = dn[0];
      launch(0, 1'b0);
      repeat (5) @(negedge clock);
      rand_stim(0);
      start_a = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      wait_n(0, base + 1, 80);

      // asynchronous reset in the middle of a scan
      launch(0, 1'b0);
      repeat (15) @(negedge clock);
      #2 reset_L = 1'b0;
      #1;
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_col", col_a, 0);
      chk("mid_rst_cnt", cnt_a, 0);
      q_a.delete();
      repeat (2) @(posedge clock);
      #1 reset_L = 1'b1;

      for (int n = 0; n < 14; n++) begin
         rand_stim(0);
         sweep(0);
      end

      // full-range corners must not overflow
      setup_far();
      for (int d = 0; d < 3; d++) begin
         st_loc[0][d] = -32768;
         st_loc[1][d] = 32767;
      end
      st_rad[0] = 127; st_rad[1] = 127;
      sweep(1);
      chk("b_corner_cnt", cnt_b, 0);
      for (int s = 0; s < S; s++) begin
         for (int d = 0; d < 3; d++) st_loc[s][d] = 0;
         st_rad[s] = 1;
      end
      sweep(1);
      chk("b_origin_cnt", cnt_b, PAIRS);
      chk("b_origin_mat", col_b, {S*S{1'b1}});

      for (int n = 0; n < 6; n++) begin
         rand_stim(1);
         sweep(1);
      end

`ifdef COLLISION_SCAN_ABORT_EN
      rand_stim(0);
      base = dn[0];
      launch(0, 1'b0);
      repeat (9) @(negedge clock);
      abort_a = 1'b1;
      @(posedge clock);
      #1 abort_a = 1'b0;
      void'(q_a.pop_back());
      stab[0]   = 1'b0;
      busy_n[0] = 0;
      chk("abort_pulse", aborted_a, 1);
      chk("abort_idle", busy_a, 0);
      @(negedge clock);
      chk("abort_single", aborted_a, 0);
      repeat (50) @(negedge clock);
      chk("abort_no_done", dn[0], base);
      sweep(0);
`endif

      repeat (4) @(negedge clock);
      chk("queues_empty", q_a.size() + q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
